// File: rtl/proj_pkg.sv
// Shared constants and types for the projection block: counter geometry,
// pass-scheduler state encoding and watchdog limit.
package proj_pkg;

    localparam int INDICE_LEN     = 3;
    localparam int FM_BUFFER_SIZE = 8;
    localparam int PASS_LEN       = 4;

    // Slack of a few cycles over one full sweep before the watchdog declares the counter stuck.
    localparam int WDOG_LIMIT     = FM_BUFFER_SIZE + 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        RUN,
        DRAIN,
        DONE
    } sched_state_t;

endpackage

// File: rtl/proj_pass_scheduler_if.sv
// Job handshake between top-level control (master) and the pass scheduler (slave).
interface proj_pass_scheduler_if #(
    parameter int PASS_LEN = proj_pkg::PASS_LEN
);
    logic                job_valid;
    logic                job_ready;
    logic [PASS_LEN-1:0] job_num_passes;
    logic                job_abort;
    logic                job_done;
    logic                job_aborted;

    modport master (
        output job_valid, job_num_passes, job_abort,
        input  job_ready, job_done, job_aborted
    );

    modport slave (
        input  job_valid, job_num_passes, job_abort,
        output job_ready, job_done, job_aborted
    );
endinterface

// File: rtl/proj_sched_wdog.sv
// Sweep watchdog: reloads on each counter start, counts while a sweep is pending,
// and flags expiry once LIMIT cycles have passed without an end-of-count.
module proj_sched_wdog #(
    parameter int LIMIT = proj_pkg::WDOG_LIMIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic active,
    output logic expire
);
    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] count;

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // flop samples the values from before the clock edge regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= W'(1);
        end else if (active && count != LAST) begin
            count <= count + 1'b1;
        end
    end

    assign expire = active && (count == LAST);
endmodule

// File: rtl/proj_pass_scheduler.sv
// Multi-pass sequencer for the projection index counter: one counter sweep per pass.
// Optional watchdog on RUN/DRAIN is enabled by defining PROJ_SCHED_WDOG_EN.
module proj_pass_scheduler #(
    parameter int INDICE_LEN = proj_pkg::INDICE_LEN,
    parameter int PASS_LEN   = proj_pkg::PASS_LEN,
    parameter int BUF_SIZE   = proj_pkg::FM_BUFFER_SIZE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    proj_pass_scheduler_if.slave  job,
    output logic                  cnt_start,
    input  logic [INDICE_LEN-1:0] cnt_index,
    input  logic                  cnt_finished,
    output logic                  buf_rd_en,
    output logic [PASS_LEN-1:0]   pass_idx,
    output logic                  pass_done,
    output logic                  busy
`ifdef PROJ_SCHED_WDOG_EN
    ,output logic                 wdog_err
`endif
);
    import proj_pkg::*;

    // pass_done is registered yet must line up with cnt_finished, so it is armed one index early.
    localparam logic [INDICE_LEN-1:0] PRE_LAST = INDICE_LEN'(BUF_SIZE - 2);

    sched_state_t        state, state_next;
    logic [PASS_LEN-1:0] passes_total;
    logic                aborted;
    logic                last_pass;
    logic                wdog_expire;
    logic                wdog_fire;

`ifdef PROJ_SCHED_WDOG_EN
    proj_sched_wdog #(.LIMIT(BUF_SIZE + 4)) u_wdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (state == START),
        .active (state == RUN || state == DRAIN),
        .expire (wdog_expire)
    );
`else
    assign wdog_expire = 1'b0;
`endif

    assign last_pass = (pass_idx == passes_total - 1'b1);
    assign wdog_fire = wdog_expire && !cnt_finished && (state == RUN || state == DRAIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: state_next gets its default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (job.job_valid) state_next = (job.job_num_passes == '0) ? DONE : START;
            START: state_next = job.job_abort ? DRAIN : RUN;
            RUN: begin
                if (cnt_finished)       state_next = (job.job_abort || last_pass) ? DONE : START;
                else if (wdog_fire)     state_next = DONE;
                else if (job.job_abort) state_next = DRAIN;
            end
            DRAIN: if (cnt_finished || wdog_fire) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            passes_total <= '0;
            pass_idx     <= '0;
            aborted      <= 1'b0;
            pass_done    <= 1'b0;
        end else begin
            pass_done <= (state == RUN) && !job.job_abort && (cnt_index == PRE_LAST);
            if (state == IDLE && job.job_valid) begin
                passes_total <= job.job_num_passes;
                pass_idx     <= '0;
                aborted      <= 1'b0;
            end
            if (state == RUN && cnt_finished && !job.job_abort && !last_pass)
                pass_idx <= pass_idx + 1'b1;
            if ((state == START || state == RUN) && job.job_abort)
                aborted <= 1'b1;
            if (wdog_fire)
                aborted <= 1'b1;
        end
    end

`ifdef PROJ_SCHED_WDOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wdog_err <= 1'b0;
        else        wdog_err <= wdog_fire;
    end
`endif

    assign cnt_start       = (state == START);
    assign buf_rd_en       = (state == RUN);
    assign busy            = (state != IDLE);
    assign job.job_ready   = (state == IDLE);
    assign job.job_done    = (state == DONE);
    assign job.job_aborted = aborted;
endmodule

// File: tb/tb_proj_pass_scheduler.sv
// Bench for proj_pass_scheduler with a behavioural projection counter (BUF_SIZE=8):
// table of whole-job vectors plus back-to-back, mid-run reset and watchdog sequences.
module tb_proj_pass_scheduler;
    localparam int BUF = 8;
    localparam int IL  = 3;
    localparam int PL  = 4;
    localparam int PER = BUF + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    proj_pass_scheduler_if #(.PASS_LEN(PL)) job_if();

    logic          cnt_start, buf_rd_en, pass_done, busy, cnt_finished;
    logic [IL-1:0] cnt_index;
    logic [PL-1:0] pass_idx;
`ifdef PROJ_SCHED_WDOG_EN
    logic          wdog_err;
`endif

    proj_pass_scheduler #(.INDICE_LEN(IL), .PASS_LEN(PL), .BUF_SIZE(BUF)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .job          (job_if),
        .cnt_start    (cnt_start),
        .cnt_index    (cnt_index),
        .cnt_finished (cnt_finished),
        .buf_rd_en    (buf_rd_en),
        .pass_idx     (pass_idx),
        .pass_done    (pass_done),
        .busy         (busy)
`ifdef PROJ_SCHED_WDOG_EN
        ,.wdog_err    (wdog_err)
`endif
    );

    // Projection counter: rising edge of start loads index 0, then counts to BUF-1 and stops.
    logic          run, start_d, force_fin_low;
    logic [IL-1:0] idx;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run <= 1'b0; idx <= '0; start_d <= 1'b0;
        end else begin
            start_d <= cnt_start;
            if (cnt_start && !start_d) begin
                run <= 1'b1; idx <= '0;
            end else if (run) begin
                if (idx == IL'(BUF - 1)) run <= 1'b0;
                else                     idx <= idx + 1'b1;
            end
        end
    end
    assign cnt_index    = idx;
    assign cnt_finished = run && (idx == IL'(BUF - 1)) && !force_fin_low;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_job_ready"},   job_if.job_ready,   1);
        check({tag, "_cnt_start"},   cnt_start,          0);
        check({tag, "_buf_rd_en"},   buf_rd_en,          0);
        check({tag, "_pass_idx"},    pass_idx,           0);
        check({tag, "_pass_done"},   pass_done,          0);
        check({tag, "_job_done"},    job_if.job_done,    0);
        check({tag, "_job_aborted"}, job_if.job_aborted, 0);
        check({tag, "_busy"},        busy,               0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one job from an IDLE cycle (cycle 0 = acceptance cycle) until job_done, then one more cycle.
    task automatic run_job(input int n, input int abort_at, output int done_c, output int ab,
                           output int starts, output int pds, output int rds);
        int bad_ready;
        done_c = -1; ab = -1; starts = 0; pds = 0; rds = 0; bad_ready = 0;
        check("ready_at_accept", job_if.job_ready, 1);
        for (int c = 0; c < 300 && done_c < 0; c++) begin
            if (cnt_start) begin
                check("start_cycle", c, 1 + PER * starts);
                starts++;
            end
            if (pass_done) begin
                check("pass_done_cycle", c, PER * (pds + 1));
                check("pass_done_idx", pass_idx, pds);
                pds++;
            end
            if (buf_rd_en) rds++;
            if (c > 0 && job_if.job_ready) bad_ready++;
            if (c == 1) check("aborted_cleared", job_if.job_aborted, 0);
            if (job_if.job_done) begin
                done_c = c;
                ab = int'(job_if.job_aborted);
            end
            job_if.job_valid      = (c == 0);
            job_if.job_num_passes = PL'(n);
            job_if.job_abort      = (c == abort_at);
            step();
        end
        job_if.job_valid = 1'b0;
        job_if.job_abort = 1'b0;
        check("ready_low_while_busy", bad_ready, 0);
    endtask

    typedef struct {
        int n;
        int abort_at;
        int exp_done;
        int exp_aborted;
        int exp_starts;
        int exp_pds;
        int exp_rds;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int done_c, ab, starts, pds, rds;
        int first_done, second_acc, second_done, bad_ready, second_start;

        vecs[0] = '{n: 3, abort_at: -1, exp_done: 28, exp_aborted: 0, exp_starts: 3, exp_pds: 3, exp_rds: 24};
        vecs[1] = '{n: 0, abort_at: -1, exp_done: 1,  exp_aborted: 0, exp_starts: 0, exp_pds: 0, exp_rds: 0};
        vecs[2] = '{n: 1, abort_at: -1, exp_done: 10, exp_aborted: 0, exp_starts: 1, exp_pds: 1, exp_rds: 8};
        vecs[3] = '{n: 3, abort_at: 5,  exp_done: 10, exp_aborted: 1, exp_starts: 1, exp_pds: 0, exp_rds: 4};
        vecs[4] = '{n: 2, abort_at: 10, exp_done: 19, exp_aborted: 1, exp_starts: 2, exp_pds: 1, exp_rds: 8};
        vecs[5] = '{n: 2, abort_at: 0,  exp_done: 19, exp_aborted: 0, exp_starts: 2, exp_pds: 2, exp_rds: 16};

        job_if.job_valid = 1'b0;
        job_if.job_num_passes = '0;
        job_if.job_abort = 1'b0;
        force_fin_low = 1'b0;

        #12;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            run_job(vecs[i].n, vecs[i].abort_at, done_c, ab, starts, pds, rds);
            check($sformatf("v%0d_done_cycle", i), done_c, vecs[i].exp_done);
            check($sformatf("v%0d_aborted", i), ab, vecs[i].exp_aborted);
            check($sformatf("v%0d_starts", i), starts, vecs[i].exp_starts);
            check($sformatf("v%0d_pass_dones", i), pds, vecs[i].exp_pds);
            check($sformatf("v%0d_rd_cycles", i), rds, vecs[i].exp_rds);
            check($sformatf("v%0d_aborted_held", i), job_if.job_aborted, vecs[i].exp_aborted);
            check($sformatf("v%0d_idle_ready", i), job_if.job_ready, 1);
        end

        // Back-to-back: N=1 then N=2 with job_valid held high throughout.
        first_done = -1; second_acc = -1; second_done = -1; bad_ready = 0; second_start = -1;
        job_if.job_valid = 1'b1;
        job_if.job_num_passes = PL'(1);
        for (int c = 0; c < 80; c++) begin
            if (job_if.job_done) begin
                if (first_done < 0) first_done = c;
                else                second_done = c;
            end
            if (c >= 1 && c <= 10 && job_if.job_ready) bad_ready++;
            if (c > 0 && job_if.job_ready && job_if.job_valid && second_acc < 0) second_acc = c;
            if (second_acc >= 0 && c > second_acc && cnt_start && second_start < 0) second_start = c;
            if (c >= 1) job_if.job_num_passes = PL'(2);
            if (second_acc >= 0 && c > second_acc) job_if.job_valid = 1'b0;
            step();
            if (second_done >= 0) break;
        end
        job_if.job_valid = 1'b0;
        check("b2b_first_done", first_done, 10);
        check("b2b_ready_low", bad_ready, 0);
        check("b2b_second_accept", second_acc, 11);
        check("b2b_second_start", second_start, 12);
        check("b2b_second_done", second_done, 30);

        // Reset mid-RUN at pass 1, index 5.
        job_if.job_valid = 1'b1;
        job_if.job_num_passes = PL'(3);
        step();
        job_if.job_valid = 1'b0;
        for (int c = 1; c < 16; c++) step();
        check("midrst_pass_idx", pass_idx, 1);
        check("midrst_index", cnt_index, 5);
        check("midrst_rd_en_before", buf_rd_en, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        step();
        rst_n = 1'b1;
        step();
        run_job(1, -1, done_c, ab, starts, pds, rds);
        check("post_reset_done_cycle", done_c, 10);
        check("post_reset_aborted", ab, 0);

`ifdef PROJ_SCHED_WDOG_EN
        // Stuck counter: watchdog ends the job 12 cycles after START (cycle 1).
        begin
            int err_c, wd_done, wd_ab;
            err_c = -1; wd_done = -1; wd_ab = -1;
            force_fin_low = 1'b1;
            job_if.job_valid = 1'b1;
            job_if.job_num_passes = PL'(1);
            step();
            job_if.job_valid = 1'b0;
            for (int c = 1; c < 40; c++) begin
                if (wdog_err && err_c < 0) err_c = c;
                if (job_if.job_done && wd_done < 0) begin
                    wd_done = c;
                    wd_ab = int'(job_if.job_aborted);
                end
                step();
            end
            force_fin_low = 1'b0;
            check("wdog_err_cycle", err_c, 13);
            check("wdog_done_cycle", wd_done, 13);
            check("wdog_aborted", wd_ab, 1);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
